// File: rtl/kmeans_stream_tx.sv
// Host-side k-means stream driver: sends centroids + points from source memory, then
// collects CLUSTER_SIZE result centroids. Optional result-wait abort: KMEANS_TX_TIMEOUT_EN.
module kmeans_stream_tx #(
  parameter int unsigned CLUSTER_SIZE   = 4,
  parameter int unsigned DATA_SIZE      = 4096,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [15:0]               mem_rdata,
  output logic                      tx_valid,
  output logic [15:0]               tx_data,
  input  logic                      rx_valid,
  input  logic [15:0]               rx_data,
  output logic [16*CLUSTER_SIZE-1:0] result_flat
);

  localparam int unsigned TOTAL = CLUSTER_SIZE + DATA_SIZE;
  localparam int unsigned CNT_W = (CLUSTER_SIZE > 1) ? $clog2(CLUSTER_SIZE) : 1;
  localparam int unsigned RES_W = 16 * CLUSTER_SIZE;
  localparam int unsigned TMO_W = 20;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(CLUSTER_SIZE - 1);

  if (64'(TOTAL) > (64'd1 << ADDR_W) || TIMEOUT_CYCLES == 32'd0 ||
      TIMEOUT_CYCLES > (32'd1 << TMO_W)) begin : g_cfg_check
    $error("kmeans_stream_tx: invalid parameterisation");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DRAIN, S_WAIT_RES, S_CAPTURE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               rd_vld_q, rd_vld_d;
  logic               tx_valid_q, tx_valid_d;
  logic [15:0]        tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   result_q, result_d;
`ifdef KMEANS_TX_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // Next-state and registered-output logic; read data is forwarded one stage behind mem_rd
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_vld_d   = mem_rd_q;
    tx_valid_d = rd_vld_q;
    tx_data_d  = rd_vld_q ? mem_rdata : 16'h0000;
    cnt_d      = cnt_q;
    result_d   = result_q;
`ifdef KMEANS_TX_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_STREAM;
          busy_d     = 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = '0;
          cnt_d      = '0;
`ifdef KMEANS_TX_TIMEOUT_EN
          tmo_cnt_d  = '0;
          timeout_d  = 1'b0;
`endif
        end
      end
      S_STREAM: begin
        if (mem_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (!rd_vld_q) state_d = S_WAIT_RES;
      end
      S_WAIT_RES, S_CAPTURE: begin
        if (rx_valid) begin
          for (int unsigned i = 0; i < CLUSTER_SIZE; i++) begin
            if (cnt_q == CNT_W'(i)) result_d[16*i +: 16] = rx_data;
          end
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_CAPTURE;
        end
`ifdef KMEANS_TX_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        if (rx_valid && cnt_q == LAST_WORD) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
`ifdef KMEANS_TX_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
`ifdef KMEANS_TX_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      rd_vld_q   <= rd_vld_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
`ifdef KMEANS_TX_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign result_flat = result_q;
`ifdef KMEANS_TX_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_stream_tx.sv
// Self-checking bench for kmeans_stream_tx: randomized job images and result words
// compared against a queue/array reference of the expected stream and captured centroids.
module tb_kmeans_stream_tx;

  localparam int CS  = 4;
  localparam int DS  = 8;
  localparam int AW  = 4;
  localparam int TOT = CS + DS;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              rst, start, rx_valid;
  logic [15:0]       rx_data;
  logic [15:0]       mem_rdata;
  logic              busy, done, timeout, mem_rd, tx_valid;
  logic [AW-1:0]     mem_addr;
  logic [15:0]       tx_data;
  logic [16*CS-1:0]  result_flat;

  logic [15:0] mem [2**AW];
  logic [15:0] exp_res [CS];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_edge = 0;

  int          rd_addrs [$];
  logic [15:0] tx_words [$];
  int tx_rises = 0, rd_rises = 0, last_tx_rise = 0, done_cnt = 0;
  logic mem_rd_prev = 1'b0, tx_valid_prev = 1'b0;

  kmeans_stream_tx #(
    .CLUSTER_SIZE(CS), .DATA_SIZE(DS), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .result_flat(result_flat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source memory: data one cycle after the read request
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Observation log of the memory and accelerator-side traffic
  always @(negedge clk) begin
    if (mem_rd) rd_addrs.push_back(int'(mem_addr));
    if (mem_rd && !mem_rd_prev) rd_rises++;
    if (tx_valid) tx_words.push_back(tx_data);
    if (tx_valid && !tx_valid_prev) begin
      tx_rises++;
      last_tx_rise = cyc;
    end
    if (done) done_cnt++;
    mem_rd_prev   = mem_rd;
    tx_valid_prev = tx_valid;
  end

  function automatic logic [16*CS-1:0] exp_flat();
    logic [16*CS-1:0] f;
    for (int i = 0; i < CS; i++) f[16*i +: 16] = exp_res[i];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2**AW; i++) mem[i] = 16'($urandom);
  endtask

  task automatic start_job();
    start = 1'b1;
    step();
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_stream(output bit ok);
    ok = 1'b0;
    for (int j = 0; j < 4*TOT + 20; j++) begin
      step();
      if (cyc > start_edge + 2 && !mem_rd && !tx_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic send_results();
    for (int i = 0; i < CS; i++) begin
      exp_res[i] = 16'($urandom);
      rx_valid = 1'b1;
      rx_data  = exp_res[i];
      step();
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
    for (int i = 0; i < CS; i++) exp_res[i] = 16'h0;
    step(); step();
    n_cmp++; if ({busy, done, timeout, mem_rd, tx_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, timeout, mem_rd, tx_valid});
    end
    n_cmp++; if (mem_addr !== 4'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    n_cmp++; if (tx_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_txdata: got %h expected 0", tx_data);
    end
    n_cmp++; if (result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL reset_result: got %h expected %h", result_flat, exp_flat());
    end
    rst = 1'b0;
    step(); step();
    n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b rd=%b done=%b expected 0", busy, mem_rd, done);
    end
  endtask

  task automatic test_stream();
    int b_rd, b_tx, b_txr, b_rdr, b_done;
    bit ok;
    for (int i = 0; i < 2**AW; i++) mem[i] = 16'(16'h0101 * (i + 1));
    b_rd = rd_addrs.size(); b_tx = tx_words.size(); b_txr = tx_rises; b_rdr = rd_rises; b_done = done_cnt;
    start_job();
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 4'h0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL accept: got rd=%b addr=%h busy=%b expected 1 0 1", mem_rd, mem_addr, busy);
    end
    wait_stream(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stream_end: got timeout expected stream end"); end
    n_cmp++; if (rd_addrs.size() - b_rd !== TOT || rd_rises - b_rdr !== 1) begin
      n_fail++; $display("FAIL rd_count: got %0d reads in %0d bursts expected %0d in 1", rd_addrs.size() - b_rd, rd_rises - b_rdr, TOT);
    end
    for (int i = 0; i < TOT && b_rd + i < rd_addrs.size(); i++) begin
      n_cmp++; if (rd_addrs[b_rd + i] !== i) begin
        n_fail++; $display("FAIL rd_addr[%0d]: got %0d expected %0d", i, rd_addrs[b_rd + i], i);
      end
    end
    n_cmp++; if (tx_words.size() - b_tx !== TOT || tx_rises - b_txr !== 1) begin
      n_fail++; $display("FAIL tx_count: got %0d words in %0d bursts expected %0d in 1", tx_words.size() - b_tx, tx_rises - b_txr, TOT);
    end
    n_cmp++; if (last_tx_rise - start_edge !== 2) begin
      n_fail++; $display("FAIL tx_latency: got %0d expected 2", last_tx_rise - start_edge);
    end
    for (int i = 0; i < TOT && b_tx + i < tx_words.size(); i++) begin
      n_cmp++; if (tx_words[b_tx + i] !== mem[i]) begin
        n_fail++; $display("FAIL tx_word[%0d]: got %h expected %h", i, tx_words[b_tx + i], mem[i]);
      end
    end
    for (int i = 0; i < CS; i++) begin
      exp_res[i] = 16'(16'h1111 * (i + 1));
      rx_valid = 1'b1;
      rx_data  = exp_res[i];
      step();
      if (i < CS - 1) begin
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done[%0d]: got 1 expected 0", i); end
      end
    end
    rx_valid = 1'b0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got done=%b busy=%b expected 1 0", done, busy);
    end
    n_cmp++; if (result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL result_seq: got %h expected %h", result_flat, exp_flat());
    end
    step();
    n_cmp++; if (done !== 1'b0 || done_cnt - b_done !== 1) begin
      n_fail++; $display("FAIL done_width: got done=%b pulses=%0d expected 0 1", done, done_cnt - b_done);
    end
  endtask

  task automatic test_rx_gaps();
    int pat [6] = '{1, 0, 1, 1, 0, 1};
    int k = 0;
    bit ok;
    fill_random();
    start_job();
    wait_stream(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL gaps_stream_end: got timeout expected stream end"); end
    for (int i = 0; i < 6; i++) begin
      rx_valid = pat[i][0];
      rx_data  = 16'($urandom);
      if (pat[i] == 1) begin exp_res[k] = rx_data; k++; end
      step();
      n_cmp++; if (done !== (i == 5)) begin
        n_fail++; $display("FAIL gaps_done[%0d]: got %b expected %b", i, done, i == 5);
      end
    end
    rx_valid = 1'b0;
    n_cmp++; if (result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL gaps_result: got %h expected %h", result_flat, exp_flat());
    end
  endtask

  task automatic test_ignore_while_busy();
    int b_rd, b_tx, b_txr;
    bit ok = 1'b0;
    step(); step();
    fill_random();
    b_rd = rd_addrs.size(); b_tx = tx_words.size(); b_txr = tx_rises;
    start_job();
    for (int j = 0; j < 4*TOT + 20; j++) begin
      start    = (j == 2 || j == 7);
      rx_valid = (j % 3 == 0);
      rx_data  = 16'($urandom);
      step();
      if (cyc > start_edge + 2 && !mem_rd && !tx_valid) begin ok = 1'b1; break; end
    end
    start = 1'b0; rx_valid = 1'b0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ign_stream_end: got timeout expected stream end"); end
    n_cmp++; if (rd_addrs.size() - b_rd !== TOT || tx_words.size() - b_tx !== TOT || tx_rises - b_txr !== 1) begin
      n_fail++; $display("FAIL ign_counts: got rd=%0d tx=%0d bursts=%0d expected %0d %0d 1",
                         rd_addrs.size() - b_rd, tx_words.size() - b_tx, tx_rises - b_txr, TOT, TOT);
    end
    for (int i = 0; i < TOT && b_tx + i < tx_words.size() && b_rd + i < rd_addrs.size(); i++) begin
      n_cmp++; if (tx_words[b_tx + i] !== mem[i] || rd_addrs[b_rd + i] !== i) begin
        n_fail++; $display("FAIL ign_word[%0d]: got addr=%0d data=%h expected %0d %h", i, rd_addrs[b_rd + i], tx_words[b_tx + i], i, mem[i]);
      end
    end
    n_cmp++; if (result_flat !== exp_flat() || busy !== 1'b1) begin
      n_fail++; $display("FAIL ign_no_capture: got %h busy=%b expected %h busy=1", result_flat, busy, exp_flat());
    end
    send_results();
    n_cmp++; if (done !== 1'b1 || result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL ign_result: got done=%b %h expected 1 %h", done, result_flat, exp_flat());
    end
  endtask

  task automatic test_back_to_back();
    int b_tx;
    bit ok;
    step();
    fill_random();
    start_job();
    wait_stream(ok);
    send_results();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    fill_random();
    b_tx = tx_words.size();
    start = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_in_done: got busy=%b rd=%b expected 0 0", busy, mem_rd);
    end
    step();
    start = 1'b0;
    start_edge = cyc;
    n_cmp++; if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b rd=%b addr=%h expected 1 1 0", busy, mem_rd, mem_addr);
    end
    wait_stream(ok);
    n_cmp++; if (!ok || tx_words.size() - b_tx !== TOT) begin
      n_fail++; $display("FAIL b2b_stream: got ok=%b words=%0d expected 1 %0d", ok, tx_words.size() - b_tx, TOT);
    end
    for (int i = 0; i < TOT && b_tx + i < tx_words.size(); i++) begin
      n_cmp++; if (tx_words[b_tx + i] !== mem[i]) begin
        n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, tx_words[b_tx + i], mem[i]);
      end
    end
    send_results();
    n_cmp++; if (result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL b2b_result: got %h expected %h", result_flat, exp_flat());
    end
  endtask

  task automatic test_reset_mid_stream();
    int b_tx, b_rd;
    bit ok, found = 1'b0;
    step();
    fill_random();
    b_tx = tx_words.size();
    start_job();
    for (int j = 0; j < 40; j++) begin
      step();
      if (tx_valid && tx_words.size() - b_tx == 5) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found || tx_data !== mem[5]) begin
      n_fail++; $display("FAIL mid_word5: got found=%b data=%h expected 1 %h", found, tx_data, mem[5]);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_reset: got tx=%b rd=%b busy=%b expected 0 0 0", tx_valid, mem_rd, busy);
    end
    for (int i = 0; i < CS; i++) exp_res[i] = 16'h0;
    n_cmp++; if (result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL mid_result_clear: got %h expected %h", result_flat, exp_flat());
    end
    step();
    rst = 1'b0;
    step();
    fill_random();
    b_tx = tx_words.size(); b_rd = rd_addrs.size();
    start_job();
    wait_stream(ok);
    n_cmp++; if (!ok || rd_addrs.size() - b_rd !== TOT || tx_words.size() - b_tx !== TOT) begin
      n_fail++; $display("FAIL mid_restart: got ok=%b rd=%0d tx=%0d expected 1 %0d %0d", ok, rd_addrs.size() - b_rd, tx_words.size() - b_tx, TOT, TOT);
    end
    for (int i = 0; i < TOT && b_tx + i < tx_words.size() && b_rd + i < rd_addrs.size(); i++) begin
      n_cmp++; if (tx_words[b_tx + i] !== mem[i] || rd_addrs[b_rd + i] !== i) begin
        n_fail++; $display("FAIL mid_word[%0d]: got addr=%0d data=%h expected %0d %h", i, rd_addrs[b_rd + i], tx_words[b_tx + i], i, mem[i]);
      end
    end
    send_results();
    n_cmp++; if (done !== 1'b1 || result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL mid_result: got done=%b %h expected 1 %h", done, result_flat, exp_flat());
    end
  endtask

  task automatic test_timeout();
    bit ok, seen = 1'b0;
    int w_edge, d_edge = 0;
    step();
    fill_random();
    start_job();
    wait_stream(ok);
    w_edge = cyc;
    for (int j = 0; j < 100; j++) begin
      step();
      if (done) begin seen = 1'b1; d_edge = cyc; break; end
    end
`ifdef KMEANS_TX_TIMEOUT_EN
    n_cmp++; if (!seen || d_edge - w_edge !== TMO) begin
      n_fail++; $display("FAIL tmo_latency: got seen=%b cycles=%0d expected 1 %0d", seen, d_edge - w_edge, TMO);
    end
    n_cmp++; if (timeout !== 1'b1 || busy !== 1'b0 || result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL tmo_abort: got timeout=%b busy=%b res=%h expected 1 0 %h", timeout, busy, result_flat, exp_flat());
    end
    step(); step(); step();
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", timeout); end
    fill_random();
    start_job();
    n_cmp++; if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL tmo_clear: got timeout=%b busy=%b expected 0 1", timeout, busy);
    end
    wait_stream(ok);
`else
    n_cmp++; if (seen || busy !== 1'b1 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL wait_forever: got done_seen=%b busy=%b timeout=%b expected 0 1 0", seen, busy, timeout);
    end
`endif
    send_results();
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b0 || result_flat !== exp_flat()) begin
      n_fail++; $display("FAIL tmo_next_job: got done=%b timeout=%b %h expected 1 0 %h", done, timeout, result_flat, exp_flat());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_rx_gaps();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid_stream();
    test_timeout();
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kmeans_stream_tx.md
Name: kmeans_stream_tx

Overview:
Host-side driver for the k-means accelerator stream interface. It reads a job image from a word-addressed source memory and transmits it on the accelerator's input port: CLUSTER_SIZE initial centroids, then DATA_SIZE points, with valid held contiguously. It then collects the CLUSTER_SIZE result centroids from the accelerator's output port and presents them to the host with a done pulse.

Parameters:
CLUSTER_SIZE, 4, centroid words sent first and result words collected.
DATA_SIZE, 4096, data-point words sent after the centroids.
ADDR_W, 13, source memory address width; must satisfy 2^ADDR_W >= CLUSTER_SIZE+DATA_SIZE.
TIMEOUT_CYCLES, 1048576, result-wait limit; used only with KMEANS_TX_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  job request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when results are valid or on abort
timeout  out  1  sticky abort flag, cleared on next accepted start (feature only, else tied 0)
mem_rd  out  1  source memory read enable, registered
mem_addr  out  ADDR_W  source memory address, registered
mem_rdata  in  16  source read data, valid one cycle after mem_rd/mem_addr
tx_valid  out  1  drives accelerator in_valid
tx_data  out  16  drives accelerator in_data; [15:8]=x, [7:0]=y
rx_valid  in  1  from accelerator out_valid
rx_data  in  16  from accelerator out_data
result_flat  out  16*CLUSTER_SIZE  captured centroids; word i at [16i+15:16i]

Behaviour:
- Reset (async, rst=1): state IDLE. busy, done, timeout, mem_rd, tx_valid = 0. mem_addr, tx_data, result_flat = 0. All counters = 0.
- Job image layout: addresses 0..CLUSTER_SIZE-1 hold initial centroids; CLUSTER_SIZE..CLUSTER_SIZE+DATA_SIZE-1 hold points. TOTAL = CLUSTER_SIZE+DATA_SIZE.
- IDLE:
  - start=1 at edge k -> STREAM. After edge k: mem_rd=1, mem_addr=0, busy=1.
  - start while busy is ignored.
- STREAM:
  - mem_addr increments by 1 each cycle. mem_rd stays high exactly TOTAL cycles (addresses 0..TOTAL-1), then drops.
  - Read-valid is pipelined one stage. At edge k+2+i: tx_data <= word i, tx_valid <= 1.
  - tx_valid is high for exactly TOTAL consecutive cycles with no bubbles. The accelerator treats the first low cycle as end of data, so a gap is a protocol violation.
  - After the last address is issued -> DRAIN.
- DRAIN:
  - Waits for the pipeline to empty. The edge after the last word is presented sets tx_valid=0 and tx_data=0.
  - Then -> WAIT_RES.
- WAIT_RES:
  - rx_valid is ignored in every state except WAIT_RES and CAPTURE.
  - First rx_valid=1: rx_data is stored in result word 0 -> CAPTURE.
- CAPTURE:
  - Each rx_valid=1 cycle stores rx_data into the next result word, using a 2-bit-wide (log2 CLUSTER_SIZE) counter.
  - A gap in rx_valid holds the counter; capture resumes on the next valid.
  - When word CLUSTER_SIZE-1 is stored -> DONE. Further rx_valid in the same job is ignored.
- DONE:
  - done=1 for one cycle; busy drops in the same cycle; result_flat is stable from this cycle until the next accepted start.
  - Then -> IDLE.
  - The earliest next start is accepted in the IDLE cycle after DONE. This guarantees at least one tx_valid-low cycle between jobs.
- result_flat is not cleared at start; each word is overwritten as it is captured.
- Simultaneous start and rst: reset wins.
- Reset mid-stream: tx_valid drops immediately, asynchronously. The downstream accelerator must also be reset by its owner.

Optional Feature:
- KMEANS_TX_TIMEOUT_EN defined:
  - A 20-bit cycle counter runs in WAIT_RES and CAPTURE and clears on entry to STREAM.
  - On reaching TIMEOUT_CYCLES-1 with results incomplete: timeout=1, done pulses, go to IDLE. Partially captured words remain in result_flat.
- Undefined: no counter is built, the block waits indefinitely, and the timeout port is tied 0.

Test Plan:
- DATA_SIZE=8, memory = 0x0101,0x0202,...,0x0C0C; start pulse -> mem_rd high 12 cycles at addresses 0..11; tx_valid high 12 contiguous cycles starting 2 edges after start; tx_data = 0x0101..0x0C0C in order.
- After stream, drive rx_valid 4 cycles with 0x1111,0x2222,0x3333,0x4444 -> done one cycle; result_flat = 0x4444_3333_2222_1111; busy 0.
- rx_valid pattern 1,0,1,1,0,1 with data A,x,B,C,x,D -> results A,B,C,D; done after D.
- start re-pulsed during STREAM and rx_valid pulsed during STREAM -> no restart, no capture, stream unchanged.
- rst asserted mid-STREAM (word 5) -> tx_valid, mem_rd, busy = 0 the same cycle; a new start then streams from address 0.
- KMEANS_TX_TIMEOUT_EN with TIMEOUT_CYCLES=64, no rx_valid -> done and timeout high 64 cycles after WAIT_RES entry; the next start clears timeout.
